// File: rtl/paramvec_pkg.sv
// Shared types and default geometry for the packed parameter-result vector unpacker.
package paramvec_pkg;

  localparam int WORDW_DEF   = 128;
  localparam int FW_DEF      = 6;
  localparam int NFIELDS_DEF = 15;
  localparam int OUTW_DEF    = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic [FW_DEF-1:0] field_t;

  // Index width that stays legal for a single-field vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/paramvec_field_ext.sv
// Combinational FW->OUTW extension of one field, sign- or zero-extended on request.
module paramvec_field_ext
  import paramvec_pkg::*;
#(
  parameter int FW   = FW_DEF,
  parameter int OUTW = OUTW_DEF
) (
  input  logic [FW-1:0]   field,
  input  logic            is_signed,
  output logic [OUTW-1:0] ext
);

  if (OUTW > FW) begin : g_extend
    assign ext = {{(OUTW-FW){is_signed & field[FW-1]}}, field};
  end else begin : g_same
    logic unused_sign;
    assign unused_sign = is_signed;
    assign ext         = field;
  end

endmodule

// File: rtl/paramvec_unpacker.sv
// Accepts one packed word and streams its fields out one per handshake, field 0 first.
// Define PARAMVEC_CHECK_EN to compare every field against EXPECT and count mismatches.
module paramvec_unpacker
  import paramvec_pkg::*;
#(
  parameter int                 WORDW       = WORDW_DEF,
  parameter int                 FW          = FW_DEF,
  parameter int                 NFIELDS     = NFIELDS_DEF,
  parameter int                 OUTW        = OUTW_DEF,
  parameter logic [NFIELDS-1:0] SIGNED_MASK = 'h07E0,
  parameter logic [FW-1:0]      EXPECT [NFIELDS] = '{default: '0}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORDW-1:0]              in_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUTW-1:0]               out_field,
  output logic [idx_width(NFIELDS)-1:0] out_idx,
  output logic                          out_last,
  output logic                          chk_err,
  output logic [7:0]                    chk_count
);

  localparam int             DATAW    = NFIELDS * FW;
  localparam int             PADW     = WORDW - DATAW;
  localparam int             IW       = idx_width(NFIELDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NFIELDS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DATAW-1:0] word_q, word_d;
  logic [FW-1:0]    fields [NFIELDS];
  logic [FW-1:0]    cur_field;
  logic             in_fire, out_fire, pad_nz;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_idx   = idx_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    for (int i = 0; i < NFIELDS; i++) fields[i] = word_q[i*FW +: FW];
  end
  assign cur_field = fields[idx_q];

  if (PADW > 0) begin : g_pad
    assign pad_nz = |in_word[WORDW-1:DATAW];
  end else begin : g_nopad
    assign pad_nz = 1'b0;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          word_d  = in_word[DATAW-1:0];
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // Returning to IDLE on the last beat keeps in_ready low during that handshake.
        if (out_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured word is reset too, so out_field reads 0 straight out of reset.
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  paramvec_field_ext #(
    .FW   (FW),
    .OUTW (OUTW)
  ) u_ext (
    .field     (cur_field),
    .is_signed (SIGNED_MASK[idx_q]),
    .ext       (out_field)
  );

`ifdef PARAMVEC_CHECK_EN
  logic [7:0] chk_count_q, chk_count_d;
  logic       chk_err_q, chk_err_d, mismatch;

  // Pad bits are judged at capture, fields at their output handshake; never both at once.
  always_comb begin
    mismatch    = (in_fire && pad_nz) || (out_fire && (cur_field != EXPECT[idx_q]));
    chk_err_d   = chk_err_q | mismatch;
    chk_count_d = chk_count_q;
    if (mismatch && (chk_count_q != 8'hFF)) chk_count_d = chk_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q   <= 1'b0;
      chk_count_q <= '0;
    end else begin
      chk_err_q   <= chk_err_d;
      chk_count_q <= chk_count_d;
    end
  end

  assign chk_err   = chk_err_q;
  assign chk_count = chk_count_q;
`else
  logic unused_pad;
  assign unused_pad = pad_nz;
  assign chk_err    = 1'b0;
  assign chk_count  = '0;
`endif

endmodule

// File: tb/tb_paramvec_unpacker.sv
// Self-checking bench for paramvec_unpacker: table vectors, corner sequences, random words.
module tb_paramvec_unpacker;
  import paramvec_pkg::*;

  localparam int WORDW = 128;
  localparam int FW    = 6;
  localparam int NF    = 15;
  localparam int OUTW  = 8;
  localparam logic [NF-1:0] MASK = 15'h07E0;
  localparam logic [FW-1:0] EXP_TBL [NF] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h00,
                                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
`ifdef PARAMVEC_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WORDW-1:0] in_word = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUTW-1:0]  out_field;
  logic [3:0]       out_idx;
  logic             out_last;
  logic             chk_err;
  logic [7:0]       chk_count;

  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;
  bit         exp_err = 1'b0;
  logic [7:0] seen [NF];

  typedef struct {
    logic [FW-1:0]   val;
    int              idx;
    logic [OUTW-1:0] exp;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  paramvec_unpacker #(
    .WORDW       (WORDW),
    .FW          (FW),
    .NFIELDS     (NF),
    .OUTW        (OUTW),
    .SIGNED_MASK (MASK),
    .EXPECT      (EXP_TBL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .chk_err   (chk_err),
    .chk_count (chk_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Two's-complement reinterpretation done arithmetically, then truncated to OUTW.
  function automatic logic [7:0] ext_ref(input logic [FW-1:0] f, input int i);
    int v;
    v = int'(f);
    if (MASK[i] && (v >= (1 << (FW - 1)))) v = v - (1 << FW);
    return v[7:0];
  endfunction

  function automatic void bump();
    if (CHK_EN) begin
      if (exp_cnt < 255) exp_cnt++;
      exp_err = 1'b1;
    end
  endfunction

  task automatic check_chk(input string tag);
    check({tag, "_chk_err"}, 32'(chk_err), 32'(exp_err));
    check({tag, "_chk_count"}, 32'(chk_count), exp_cnt);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_cnt = 0;
    exp_err = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Entered and left at a point 1 ns after a rising edge.
  task automatic run_word(input logic [WORDW-1:0] w, input int stall_idx, input int stall_n);
    int guard = 0;
    int reps;
    while (!in_ready && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_word  = w;
    @(posedge clk);
    #1;
    if (|w[WORDW-1:NF*FW]) bump();
    for (int b = 0; b < NF; b++) begin
      reps = (b == stall_idx) ? stall_n : 0;
      for (int k = 0; k <= reps; k++) begin
        out_ready = (k == reps);
        in_valid  = (b < NF - 1) ? 1'($urandom % 2) : 1'b0;
        in_word   = {$urandom(), $urandom(), $urandom(), $urandom()};
        check("out_valid", 32'(out_valid), 1);
        check("out_idx", 32'(out_idx), b);
        check("out_field", 32'(out_field), 32'(ext_ref(w[b*FW +: FW], b)));
        check("out_last", 32'(out_last), 32'(b == NF - 1));
        check("in_ready_busy", 32'(in_ready), 0);
        check_chk("beat");
        seen[b] = out_field;
        @(posedge clk);
        #1;
      end
      if (w[b*FW +: FW] != EXP_TBL[b]) bump();
    end
    out_ready = 1'b0;
    check("in_ready_after_last", 32'(in_ready), 1);
    check("out_valid_after_last", 32'(out_valid), 0);
    check("out_last_after_last", 32'(out_last), 0);
    check_chk("end");
  endtask

  initial begin
    logic [WORDW-1:0] w;

    vecs[0] = '{6'h08, 0, 8'h08};
    vecs[1] = '{6'h3C, 6, 8'hFC};
    vecs[2] = '{6'h3F, 5, 8'hFF};
    vecs[3] = '{6'h3F, 4, 8'h3F};
    vecs[4] = '{6'h20, 10, 8'hE0};
    vecs[5] = '{6'h20, 11, 8'h20};
    vecs[6] = '{6'h1F, 7, 8'h1F};
    vecs[7] = '{6'h3F, 14, 8'h3F};

    #12;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_field", 32'(out_field), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_last", 32'(out_last), 0);
    check_chk("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One mismatching field against the expected table.
    w = '0;
    w[3*FW +: FW] = 6'h10;
    run_word(w, -1, 0);
    check("field3_mismatch_count", 32'(chk_count), CHK_EN ? 1 : 0);

    // Matching fields with a stray pad bit.
    do_reset();
    w = '0;
    w[3*FW +: FW] = 6'h08;
    w[127] = 1'b1;
    run_word(w, -1, 0);
    check("pad_bit_count", 32'(chk_count), CHK_EN ? 1 : 0);

    w = '0;
    w[0 +: FW]    = 6'h08;
    w[6*FW +: FW] = 6'h3C;
    run_word(w, -1, 0);
    check("ex_field0", 32'(seen[0]), 32'h08);
    check("ex_field6", 32'(seen[6]), 32'hFC);

    for (int i = 0; i < 8; i++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      w[vecs[i].idx*FW +: FW] = vecs[i].val;
      run_word(w, -1, 0);
      check($sformatf("tbl%0d", i), 32'(seen[vecs[i].idx]), 32'(vecs[i].exp));
    end

    run_word({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 3);

    // Abandon a word at index 5 with an asynchronous reset.
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[127] = 1'b1;
    in_valid = 1'b1;
    in_word  = w;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_pre_idx", 32'(out_idx), 5);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_idx", 32'(out_idx), 0);
    check("midrst_chk_count", 32'(chk_count), 0);
    check("midrst_out_field", 32'(out_field), 0);
    check("midrst_out_last", 32'(out_last), 0);
    exp_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_out_valid", 32'(out_valid), 0);
    check("postrst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;

    for (int n = 0; n < 30; n++) begin
      run_word({$urandom(), $urandom(), $urandom(), $urandom()},
               int'($urandom_range(0, NF - 1)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
